regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-back queue feeding the single write port of the integer register file. It accepts results from two producers, the load/store path (`mem`) and the ALU path (`alu`), over valid/ready handshakes and buffers them in order. It drains at most one result per cycle into the register file's `RegWrite`/`rd`/`WriteData` port. It also exports a pending-write scoreboard for decode-stage stall logic.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `XLEN`, 32: data width.
- `clk`  input  1  clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `mem_valid`  input  1  load result valid.
- `mem_ready`  output  1  load result accepted when `mem_valid && mem_ready` at the edge.
- `mem_rd`  input  5  load destination register.
- `mem_data`  input  XLEN  load result.
- `alu_valid`, `alu_ready`, `alu_rd`, `alu_data`: same semantics and widths as the `mem_*` ports, for the ALU path.
- `rf_we`  output  1  register-file write enable (`RegWrite`).
- `rf_rd`  output  5  register-file write address.
- `rf_wdata`  output  XLEN  register-file write data.
- `pending`  output  32  bit i = some queued entry targets x_i.
- `count`  output  $clog2(DEPTH+1)  occupied entries.
- `q_rs1`, `q_rs2`  input  5  forwarding query addresses.
- `fwd1_hit`, `fwd2_hit`  output  1  query hit.
- `fwd1_data`, `fwd2_data`  output  XLEN  forwarded value.

## Operation
- FIFO of `{rd, data}` entries.
- Head drives `rf_we`, `rf_rd` and `rf_wdata` combinationally. The head pops on every edge where the queue is non-empty; the register file captures it on that same edge.
- Ready rules depend only on `count`, with no valid→ready path:
  - `mem_ready = count ≤ DEPTH-1`
  - `alu_ready = count ≤ DEPTH-2`
  - Both ready signals are 0 while `reset` is low.
- Free-slot computation ignores the same-cycle pop; readiness is conservative.
- Both producers may transfer in the same cycle. Enqueue order is the `mem` entry first, then the `alu` entry, so ALU data is younger.
- Transfers with rd=0 complete the handshake but are not enqueued.
- When the queue is empty: `rf_we=0`, `rf_rd=0`, `rf_wdata=0`.
- `pending` is the OR-decode of `rd` over all valid entries. Bit 0 is always 0.
- Duplicate rd values are legal; entries are written in queue order, so the youngest value lands last.
- Pointers wrap modulo DEPTH. `count` is never above DEPTH, and no accepted transfer is ever dropped.

## Timing
- Latency: a transfer accepted at edge k with an empty queue gives `rf_we=1` during cycle k→k+1. The register file is written at edge k+1.
- Throughput: 1 drain per cycle and up to 2 enqueues per cycle.
- `pending` and `count` update at the edge, after both pop and push.
- Reset low: queue empties immediately (asynchronously). Effects:
  - `rf_we`, `rf_rd`, `rf_wdata`, `pending`, `count` and all `fwd*` outputs go to 0.
  - In-flight entries are discarded.
  - `mem_ready` and `alu_ready` return to 1 on the first cycle after release.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined:
  - `fwdN_hit=1` when any valid entry has `rd == q_rsN` and `q_rsN ≠ 0`.
  - `fwdN_data` = data of the youngest matching entry.
  - Both are combinational from queue state.
- Macro not defined: the forwarding ports remain in the interface, tied to 0, and no match logic is generated.

## Structure
- Package `wb_pkg`:
  - `REG_ADDR_W=5`, `NUM_REGS=32`.
  - `wb_entry_t` struct with fields `rd` and `data`.
- Sub-module `wb_fifo`: dual-push / single-pop circular buffer. It exposes its entry array and valid mask for the `pending` and forwarding logic.
- Top level holds the handshake, rd=0 filtering, scoreboard and forwarding.

## Test plan
- Reset asserted mid-stream with 3 entries queued → same cycle: `rf_we=0`, `count=0`, `pending=0`. After release: `mem_ready=alu_ready=1`.
- ALU transfer rd=5, data 0xDEADBEEF into an empty queue → next cycle: `rf_we=1`, `rf_rd=5`, `rf_wdata=0xDEADBEEF`, `pending[5]=1`. Cycle after: `pending=0`, `rf_we=0`.
- `mem` (rd=3, 0x11) and `alu` (rd=3, 0x22) in the same cycle → writes 0x11 then 0x22. While both are queued, `q_rs1=3` gives `fwd1_hit=1`, `fwd1_data=0x22`. With the macro undefined, `fwd1_hit=0`.
- Both producers valid continuously for 8 cycles, DEPTH=4, with incrementing data:
  - `alu_ready` drops once `count=3`.
  - `count` never exceeds 4.
  - All accepted values are written exactly once, in queue order.
- `mem` rd=0 transfer → handshake completes; `count` unchanged; `rf_we` stays 0; `pending[0]=0`.
- `q_rs2=0` while the queue holds rd=0-free entries → `fwd2_hit=0` regardless of contents.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file write-back queue.
// wb_entry_t is the canonical 32-bit entry layout; the top builds an
// XLEN-wide variant with the same field order so the FIFO stays generic.
package wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int WB_XLEN    = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_XLEN-1:0]    data;
   } wb_entry_t;

   // One-hot decode of a destination register, used to build the scoreboard.
   function automatic logic [NUM_REGS-1:0] rdDecode(input logic [REG_ADDR_W-1:0] rd);
      return NUM_REGS'(1) << rd;
   endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of the producer handshakes, the register-file write port, the
// scoreboard outputs and the forwarding query port of the write-back queue.
// master = producers/decode side, slave = the write-back queue itself.
interface regfile_writeback_if #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
);
   import wb_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                  mem_valid;
   logic                  mem_ready;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic [XLEN-1:0]       mem_data;

   logic                  alu_valid;
   logic                  alu_ready;
   logic [REG_ADDR_W-1:0] alu_rd;
   logic [XLEN-1:0]       alu_data;

   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_rd;
   logic [XLEN-1:0]       rf_wdata;

   logic [NUM_REGS-1:0]   pending;
   logic [CNT_W-1:0]      count;

   logic [REG_ADDR_W-1:0] q_rs1;
   logic [REG_ADDR_W-1:0] q_rs2;
   logic                  fwd1_hit;
   logic                  fwd2_hit;
   logic [XLEN-1:0]       fwd1_data;
   logic [XLEN-1:0]       fwd2_data;

   modport master (
      output mem_valid, mem_rd, mem_data,
      output alu_valid, alu_rd, alu_data,
      output q_rs1, q_rs2,
      input  mem_ready, alu_ready,
      input  rf_we, rf_rd, rf_wdata,
      input  pending, count,
      input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
   );

   modport slave (
      input  mem_valid, mem_rd, mem_data,
      input  alu_valid, alu_rd, alu_data,
      input  q_rs1, q_rs2,
      output mem_ready, alu_ready,
      output rf_we, rf_rd, rf_wdata,
      output pending, count,
      output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
   );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: dual-push / single-pop circular buffer. Push slot 0 is always
// older than push slot 1. The whole entry array and its valid mask are
// exported so the owner can build a scoreboard and forwarding network.
// The caller guarantees it never pushes more than the free space and never
// pops when empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = wb_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push0,
   input  entry_t           i_data0,
   input  logic             i_push1,
   input  entry_t           i_data1,
   input  logic             i_pop,
   output entry_t           o_entries [DEPTH],
   output logic [DEPTH-1:0] o_valid,
   output logic [PTR_W-1:0] o_rdPtr,
   output logic [CNT_W-1:0] o_count
);

   entry_t           r_entries [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   logic [1:0]       w_nPush;
   logic [PTR_W-1:0] w_slot1;

   // Slot 1 lands right behind slot 0 when both push, otherwise at the write pointer.
   always_comb begin
      w_nPush = {1'b0, i_push0} + {1'b0, i_push1};
      w_slot1 = r_wrPtr + PTR_W'(i_push0);
   end

   // Pointer, occupancy and valid-mask bookkeeping; reset discards every entry at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (i_pop) begin
            r_valid[r_rdPtr] <= 1'b0;
            r_rdPtr          <= r_rdPtr + PTR_W'(1);
         end
         if (i_push0) begin
            r_valid[r_wrPtr] <= 1'b1;
         end
         if (i_push1) begin
            r_valid[w_slot1] <= 1'b1;
         end
         r_wrPtr <= r_wrPtr + PTR_W'(w_nPush);
         r_count <= r_count + CNT_W'(w_nPush) - CNT_W'(i_pop);
      end
   end

   // Payload storage needs no reset: nothing reads an entry whose valid bit is clear.
   always_ff @(posedge clk) begin
      if (i_push0) begin
         r_entries[r_wrPtr] <= i_data0;
      end
      if (i_push1) begin
         r_entries[w_slot1] <= i_data1;
      end
   end

   assign o_entries = r_entries;
   assign o_valid   = r_valid;
   assign o_rdPtr   = r_rdPtr;
   assign o_count   = r_count;

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write-back queue in front of the single
// register-file write port. Accepts mem and ALU results (mem is older when
// both arrive together), drops rd=0 results after the handshake, drains one
// entry per cycle and exports a pending-write scoreboard.
// Optional feature: define REGFILE_WB_BYPASS_EN to generate the forwarding
// match logic; without it the fwd* outputs are tied to zero.
module regfile_writeback
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic               clk,
   input  logic               reset,
   regfile_writeback_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] MEM_LIMIT = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] ALU_LIMIT = CNT_W'(DEPTH - 2);

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } entry_t;

   entry_t              w_entries [DEPTH];
   logic [DEPTH-1:0]    w_valid;
   logic [PTR_W-1:0]    w_rdPtr;
   logic [CNT_W-1:0]    w_count;
   logic                w_memReady;
   logic                w_aluReady;
   logic                w_memPush;
   logic                w_aluPush;
   logic                w_pop;
   entry_t              w_memEntry;
   entry_t              w_aluEntry;
   entry_t              w_head;
   logic [NUM_REGS-1:0] w_pending;
   logic                w_fwd1Hit;
   logic                w_fwd2Hit;
   logic [XLEN-1:0]     w_fwd1Data;
   logic [XLEN-1:0]     w_fwd2Data;

   // Readiness looks only at occupancy (ignoring this cycle's pop); ALU needs room behind a same-cycle mem entry.
   always_comb begin
      w_memReady = reset && (w_count <= MEM_LIMIT);
      w_aluReady = reset && (w_count <= ALU_LIMIT);
      w_memPush  = bus.mem_valid && w_memReady && (bus.mem_rd != '0);
      w_aluPush  = bus.alu_valid && w_aluReady && (bus.alu_rd != '0);
      w_pop      = (w_count != '0);
      w_memEntry = '{rd: bus.mem_rd, data: bus.mem_data};
      w_aluEntry = '{rd: bus.alu_rd, data: bus.alu_data};
   end

   wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .i_push0   (w_memPush),
      .i_data0   (w_memEntry),
      .i_push1   (w_aluPush),
      .i_data1   (w_aluEntry),
      .i_pop     (w_pop),
      .o_entries (w_entries),
      .o_valid   (w_valid),
      .o_rdPtr   (w_rdPtr),
      .o_count   (w_count)
   );

   // The head entry drives the register-file port directly and is popped on the same edge it is written.
   always_comb begin
      w_head       = w_entries[w_rdPtr];
      bus.rf_we    = 1'b0;
      bus.rf_rd    = '0;
      bus.rf_wdata = '0;
      if (w_pop) begin
         bus.rf_we    = 1'b1;
         bus.rf_rd    = w_head.rd;
         bus.rf_wdata = w_head.data;
      end
   end

   // Scoreboard: OR of every live entry's destination; x0 never counts as pending.
   always_comb begin
      w_pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_valid[i]) begin
            w_pending = w_pending | rdDecode(w_entries[i].rd);
         end
      end
      w_pending[0] = 1'b0;
   end

`ifdef REGFILE_WB_BYPASS_EN
   // Walk live entries oldest to youngest so the last match seen is the youngest value.
   always_comb begin
      logic [PTR_W-1:0] w_idx;
      w_idx      = '0;
      w_fwd1Hit  = 1'b0;
      w_fwd2Hit  = 1'b0;
      w_fwd1Data = '0;
      w_fwd2Data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = w_rdPtr + PTR_W'(k);
         if (w_valid[w_idx] && (bus.q_rs1 != '0) && (w_entries[w_idx].rd == bus.q_rs1)) begin
            w_fwd1Hit  = 1'b1;
            w_fwd1Data = w_entries[w_idx].data;
         end
         if (w_valid[w_idx] && (bus.q_rs2 != '0) && (w_entries[w_idx].rd == bus.q_rs2)) begin
            w_fwd2Hit  = 1'b1;
            w_fwd2Data = w_entries[w_idx].data;
         end
      end
   end
`else
   logic w_unusedQuery;

   assign w_fwd1Hit     = 1'b0;
   assign w_fwd2Hit     = 1'b0;
   assign w_fwd1Data    = '0;
   assign w_fwd2Data    = '0;
   assign w_unusedQuery = ^{bus.q_rs1, bus.q_rs2};
`endif

   assign bus.mem_ready = w_memReady;
   assign bus.alu_ready = w_aluReady;
   assign bus.pending   = w_pending;
   assign bus.count     = w_count;
   assign bus.fwd1_hit  = w_fwd1Hit;
   assign bus.fwd2_hit  = w_fwd2Hit;
   assign bus.fwd1_data = w_fwd1Data;
   assign bus.fwd2_data = w_fwd2Data;

endmodule

// File: tb/tb_regfile_writeback.sv
// Testbench for regfile_writeback: directed scenarios plus a randomized run,
// all checked against a queue-based model of the write-back behaviour.
module tb_regfile_writeback;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   regfile_writeback_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

   regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } mEntry_t;

   mEntry_t     mq[$];
   logic [31:0] accLog[$];
   logic [31:0] dutLog[$];
   int          checks = 0;
   int          errors = 0;

   // Drive every producer/query input, then let combinational outputs settle.
   task automatic applyStimulus(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic [4:0] rs1, input logic [4:0] rs2);
      bus.mem_valid = mv;
      bus.mem_rd    = mrd;
      bus.mem_data  = md;
      bus.alu_valid = av;
      bus.alu_rd    = ard;
      bus.alu_data  = ad;
      bus.q_rs1     = rs1;
      bus.q_rs2     = rs2;
      #1;
   endtask

   // Model scoreboard: any queued destination other than x0.
   function automatic logic [31:0] modelPending();
      logic [31:0] p = '0;
      foreach (mq[i]) p[mq[i].rd] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   // Model forwarding: youngest queued entry with a matching non-zero register.
   function automatic void modelFwd(input logic [4:0] rs, output logic hit, output logic [31:0] data);
      hit  = 1'b0;
      data = '0;
`ifdef REGFILE_WB_BYPASS_EN
      if (rs != 0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == rs) begin
               hit  = 1'b1;
               data = mq[i].data;
               break;
            end
         end
      end
`endif
   endfunction

   // Advance one clock: log the DUT write, then update the model (pop head, push accepted non-x0 results).
   task automatic tick();
      int   n    = mq.size();
      logic mAcc = bus.mem_valid && (n <= DEPTH - 1);
      logic aAcc = bus.alu_valid && (n <= DEPTH - 2);
      if (bus.rf_we) dutLog.push_back(bus.rf_wdata);
      @(posedge clk);
      if (n > 0) void'(mq.pop_front());
      if (mAcc && bus.mem_rd != 0) begin
         mq.push_back('{bus.mem_rd, bus.mem_data});
         accLog.push_back(bus.mem_data);
      end
      if (aAcc && bus.alu_rd != 0) begin
         mq.push_back('{bus.alu_rd, bus.alu_data});
         accLog.push_back(bus.alu_data);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", bus.count); end
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %0b want 0", bus.rf_we); end
      checks++; if (bus.pending !== 32'd0) begin errors++; $display("[TB] FAIL reset_pending got %0h want 0", bus.pending); end
      checks++; if ({bus.mem_ready, bus.alu_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready got %b want 00", {bus.mem_ready, bus.alu_ready}); end
      reset = 1'b1;
      #1;
      checks++; if ({bus.mem_ready, bus.alu_ready} !== 2'b11) begin errors++; $display("[TB] FAIL release_ready got %b want 11", {bus.mem_ready, bus.alu_ready}); end
      @(negedge clk);
      // Fill three entries, then assert reset asynchronously mid-cycle.
      applyStimulus(1, 5'd1, 32'h101, 1, 5'd2, 32'h102, 0, 0);
      tick();
      applyStimulus(1, 5'd3, 32'h103, 1, 5'd4, 32'h104, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd4, 0);
      checks++; if (int'(bus.count) !== 3) begin errors++; $display("[TB] FAIL midstream_count got %0d want 3", bus.count); end
      #1 reset = 1'b0;
      #1;
      mq.delete();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL async_we got %0b want 0", bus.rf_we); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL async_count got %0d want 0", bus.count); end
      checks++; if (bus.pending !== 32'd0) begin errors++; $display("[TB] FAIL async_pending got %0h want 0", bus.pending); end
      checks++; if ({bus.fwd1_hit, bus.fwd1_data} !== 33'd0) begin errors++; $display("[TB] FAIL async_fwd got %0b/%0h want 0/0", bus.fwd1_hit, bus.fwd1_data); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if ({bus.mem_ready, bus.alu_ready} !== 2'b11) begin errors++; $display("[TB] FAIL rerelease_ready got %b want 11", {bus.mem_ready, bus.alu_ready}); end
      @(negedge clk);
   endtask

   task automatic test_alu_single();
      applyStimulus(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
      checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready got %0b want 1", bus.alu_ready); end
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("[TB] FAIL single_we got %0b want 1", bus.rf_we); end
      checks++; if (bus.rf_rd !== 5'd5) begin errors++; $display("[TB] FAIL single_rd got %0d want 5", bus.rf_rd); end
      checks++; if (bus.rf_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_data got %0h want deadbeef", bus.rf_wdata); end
      checks++; if (bus.pending !== 32'h20) begin errors++; $display("[TB] FAIL single_pending got %0h want 20", bus.pending); end
      tick();
      checks++; if (bus.pending !== 32'd0) begin errors++; $display("[TB] FAIL single_pending_clr got %0h want 0", bus.pending); end
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL single_we_clr got %0b want 0", bus.rf_we); end
   endtask

   task automatic test_same_rd();
      logic        expHit;
      logic [31:0] expData;
      applyStimulus(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd3, 0);
`ifdef REGFILE_WB_BYPASS_EN
      expHit = 1'b1; expData = 32'h22;
`else
      expHit = 1'b0; expData = 32'h0;
`endif
      checks++; if (int'(bus.count) !== 2) begin errors++; $display("[TB] FAIL dup_count got %0d want 2", bus.count); end
      checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd3, 32'h11}) begin errors++; $display("[TB] FAIL dup_first got %0b/%0d/%0h want 1/3/11", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
      checks++; if ({bus.fwd1_hit, bus.fwd1_data} !== {expHit, expData}) begin errors++; $display("[TB] FAIL dup_fwd got %0b/%0h want %0b/%0h", bus.fwd1_hit, bus.fwd1_data, expHit, expData); end
      tick();
      checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd3, 32'h22}) begin errors++; $display("[TB] FAIL dup_second got %0b/%0d/%0h want 1/3/22", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
      tick();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL dup_drained got %0b want 0", bus.rf_we); end
   endtask

   task automatic test_back_to_back();
      bit sawAluDrop = 0;
      int guard = 0;
      accLog.delete();
      dutLog.delete();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 5'(1 + i), 32'(2 * i), 1, 5'(9 + i), 32'(2 * i + 1), 0, 0);
         checks++; if (bus.mem_ready !== (mq.size() <= DEPTH - 1)) begin errors++; $display("[TB] FAIL b2b_mem_ready cyc %0d got %0b", i, bus.mem_ready); end
         checks++; if (bus.alu_ready !== (mq.size() <= DEPTH - 2)) begin errors++; $display("[TB] FAIL b2b_alu_ready cyc %0d got %0b", i, bus.alu_ready); end
         checks++; if (int'(bus.count) > DEPTH || int'(bus.count) !== mq.size()) begin errors++; $display("[TB] FAIL b2b_count cyc %0d got %0d want %0d", i, bus.count, mq.size()); end
         if (int'(bus.count) == 3 && bus.alu_ready == 1'b0) sawAluDrop = 1;
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      while (mq.size() > 0 && guard < 20) begin
         tick();
         guard++;
      end
      checks++; if (mq.size() != 0) begin errors++; $display("[TB] FAIL b2b_drain_timeout left %0d want 0", mq.size()); end
      checks++; if (sawAluDrop !== 1'b1) begin errors++; $display("[TB] FAIL b2b_alu_drop got %0b want 1", sawAluDrop); end
      checks++; if (dutLog.size() !== 10) begin errors++; $display("[TB] FAIL b2b_write_count got %0d want 10", dutLog.size()); end
      checks++; if (dutLog.size() !== accLog.size()) begin errors++; $display("[TB] FAIL b2b_write_vs_accept got %0d want %0d", dutLog.size(), accLog.size()); end
      for (int i = 0; i < accLog.size() && i < dutLog.size(); i++) begin
         checks++; if (dutLog[i] !== accLog[i]) begin errors++; $display("[TB] FAIL b2b_order idx %0d got %0h want %0h", i, dutLog[i], accLog[i]); end
      end
   endtask

   task automatic test_rd_zero();
      applyStimulus(1, 5'd0, 32'hABCD, 0, 0, 0, 0, 0);
      checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("[TB] FAIL rd0_ready got %0b want 1", bus.mem_ready); end
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL rd0_count got %0d want 0", bus.count); end
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL rd0_we got %0b want 0", bus.rf_we); end
      checks++; if (bus.pending[0] !== 1'b0) begin errors++; $display("[TB] FAIL rd0_pending0 got %0b want 0", bus.pending[0]); end
   endtask

   task automatic test_fwd_zero();
      logic        h;
      logic [31:0] d;
      applyStimulus(1, 5'd7, 32'h77, 1, 5'd9, 32'h99, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
      checks++; if ({bus.fwd2_hit, bus.fwd2_data} !== 33'd0) begin errors++; $display("[TB] FAIL fwd_rs0 got %0b/%0h want 0/0", bus.fwd2_hit, bus.fwd2_data); end
      modelFwd(5'd9, h, d);
      checks++; if ({bus.fwd1_hit, bus.fwd1_data} !== {h, d}) begin errors++; $display("[TB] FAIL fwd_rs9 got %0b/%0h want %0b/%0h", bus.fwd1_hit, bus.fwd1_data, h, d); end
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd7);
      modelFwd(5'd7, h, d);
      checks++; if ({bus.fwd2_hit, bus.fwd2_data} !== {h, d}) begin errors++; $display("[TB] FAIL fwd_rs7 got %0b/%0h want %0b/%0h", bus.fwd2_hit, bus.fwd2_data, h, d); end
      tick();
      tick();
   endtask

   task automatic test_random();
      logic        h1, h2;
      logic [31:0] d1, d2;
      logic [4:0]  expRd;
      logic [31:0] expData;
      for (int c = 0; c < 300; c++) begin
         applyStimulus(logic'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                       logic'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         modelFwd(bus.q_rs1, h1, d1);
         modelFwd(bus.q_rs2, h2, d2);
         expRd   = (mq.size() > 0) ? mq[0].rd : 5'd0;
         expData = (mq.size() > 0) ? mq[0].data : 32'd0;
         checks++; if ({bus.mem_ready, bus.alu_ready} !== {mq.size() <= DEPTH - 1, mq.size() <= DEPTH - 2}) begin errors++; $display("[TB] FAIL rnd_ready cyc %0d got %b occ %0d", c, {bus.mem_ready, bus.alu_ready}, mq.size()); end
         checks++; if (int'(bus.count) !== mq.size()) begin errors++; $display("[TB] FAIL rnd_count cyc %0d got %0d want %0d", c, bus.count, mq.size()); end
         checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {mq.size() > 0, expRd, expData}) begin errors++; $display("[TB] FAIL rnd_head cyc %0d got %0b/%0d/%0h want %0b/%0d/%0h", c, bus.rf_we, bus.rf_rd, bus.rf_wdata, mq.size() > 0, expRd, expData); end
         checks++; if (bus.pending !== modelPending()) begin errors++; $display("[TB] FAIL rnd_pending cyc %0d got %0h want %0h", c, bus.pending, modelPending()); end
         checks++; if ({bus.fwd1_hit, bus.fwd1_data} !== {h1, d1}) begin errors++; $display("[TB] FAIL rnd_fwd1 cyc %0d got %0b/%0h want %0b/%0h", c, bus.fwd1_hit, bus.fwd1_data, h1, d1); end
         checks++; if ({bus.fwd2_hit, bus.fwd2_data} !== {h2, d2}) begin errors++; $display("[TB] FAIL rnd_fwd2 cyc %0d got %0b/%0h want %0b/%0h", c, bus.fwd2_hit, bus.fwd2_data, h2, d2); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_alu_single();
      test_same_rd();
      test_back_to_back();
      test_rd_zero();
      test_fwd_zero();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

endmodule
